// File: rtl/tape_controller.sv
// tape_controller: bus-mapped tape serialiser/deserialiser using pulse-width bit encoding.
// Define TAPE_CTRL_IRQ_EN to enable the interrupt output and the writable RXIE/TXIE bits.

module tape_controller (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic [1:0] ADDR,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    input  logic       TAPE_IN,
    output logic       TAPE_OUT,
    output logic       IRQ
);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HIGH = 2'd1,
        TX_LOW  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_CTRL   = 2'd1,
        ADDR_PERIOD = 2'd2,
        ADDR_RSVD   = 2'd3
    } addr_e;

    localparam logic [7:0]  PERIOD_RESET = 8'h0F;
    localparam logic [10:0] IVAL_MAX     = 11'h7FF;

    // Bus decode
    logic rd_en, wr_en, data_rd, data_wr, ctrl_wr, period_wr;

    // Prescaler and register file
    logic [3:0] presc_q, presc_d;
    logic       tick;
    logic [7:0] period_q, period_d;
    logic       rx_en_q, rx_en_d;
    logic       rxie_q, rxie_d;
    logic       txie_q, txie_d;

    // Transmitter
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bits_q, tx_bits_d;
    logic [8:0] tx_cnt_q, tx_cnt_d;
    logic       tape_out_q, tape_out_d;
    logic       tx_busy;

    // Receiver
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        rx_prev_q, rx_prev_d;
    logic        rx_armed_q, rx_armed_d;
    logic [10:0] rx_ival_q, rx_ival_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bits_q, rx_bits_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_ready_q, rx_ready_d;
    logic        overrun_q, overrun_d;
    logic        rx_rise, rx_bit, rx_set;
    logic [10:0] unit_ticks, three_u;

    // Bus outputs
    logic [7:0] dout_q, dout_d;
    logic       irq_q, irq_d;
    logic [7:0] status;

    assign rd_en     = CS & RD;
    assign wr_en     = CS & WR;
    assign data_rd   = rd_en && (ADDR == ADDR_DATA);
    assign data_wr   = wr_en && (ADDR == ADDR_DATA);
    assign ctrl_wr   = wr_en && (ADDR == ADDR_CTRL);
    assign period_wr = wr_en && (ADDR == ADDR_PERIOD);

    assign tick    = (presc_q == 4'hF);
    assign tx_busy = (tx_state_q != TX_IDLE);

    assign unit_ticks = {3'b000, period_q} + 11'd1;
    assign three_u    = (unit_ticks << 1) + unit_ticks;
    assign rx_rise    = sync2_q & ~rx_prev_q;
    assign rx_bit     = (rx_ival_q > three_u);

    assign status = {1'b0, txie_q, rxie_q, rx_en_q, sync2_q, overrun_q, rx_ready_q, tx_busy};

    // Half-bit length in ticks minus one: 1U = PERIOD+1, 2U = 2*PERIOD+2.
    function automatic logic [8:0] half_len_m1(input logic bit_val, input logic [7:0] period);
        return bit_val ? {period, 1'b1} : {1'b0, period};
    endfunction

    always_comb begin
        // NOTE: each _d defaults to its _q first so no path through the block can infer a latch.
        presc_d  = presc_q + 4'd1;
        period_d = period_q;
        rx_en_d  = rx_en_q;
        rxie_d   = rxie_q;
        txie_d   = txie_q;
        if (period_wr) begin
            period_d = DIN;
        end
        if (ctrl_wr) begin
            rx_en_d = DIN[0];
`ifdef TAPE_CTRL_IRQ_EN
            rxie_d  = DIN[1];
            txie_d  = DIN[2];
`endif
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bits_d  = tx_bits_q;
        tx_cnt_d   = tx_cnt_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (data_wr) begin
                    tx_shift_d = DIN;
                    tx_bits_d  = 3'd0;
                    tx_cnt_d   = half_len_m1(DIN[7], period_q);
                    tx_state_d = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (tick) begin
                    if (tx_cnt_q == 9'd0) begin
                        tx_state_d = TX_LOW;
                        tx_cnt_d   = half_len_m1(tx_shift_q[7], period_q);
                    end else begin
                        tx_cnt_d = tx_cnt_q - 9'd1;
                    end
                end
            end
            TX_LOW: begin
                if (tick) begin
                    if (tx_cnt_q != 9'd0) begin
                        tx_cnt_d = tx_cnt_q - 9'd1;
                    end else if (tx_bits_q == 3'd7) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        // Next bit's length comes from the bit about to move into the MSB.
                        tx_bits_d  = tx_bits_q + 3'd1;
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        tx_cnt_d   = half_len_m1(tx_shift_q[6], period_q);
                        tx_state_d = TX_HIGH;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
        tape_out_d = (tx_state_d == TX_HIGH);
    end

    always_comb begin
        sync1_d    = TAPE_IN;
        sync2_d    = sync1_q;
        rx_prev_d  = sync2_q;
        rx_armed_d = rx_armed_q;
        rx_ival_d  = rx_ival_q;
        rx_shift_d = rx_shift_q;
        rx_bits_d  = rx_bits_q;
        rx_data_d  = rx_data_q;
        rx_set     = 1'b0;
        if (!rx_en_q) begin
            rx_armed_d = 1'b0;
            rx_ival_d  = 11'd0;
            rx_bits_d  = 3'd0;
        end else if (rx_rise) begin
            // A tick coinciding with the edge is counted in the interval that starts here.
            rx_ival_d  = tick ? 11'd1 : 11'd0;
            rx_armed_d = 1'b1;
            if (rx_armed_q) begin
                rx_shift_d = {rx_shift_q[6:0], rx_bit};
                rx_bits_d  = rx_bits_q + 3'd1;
                if (rx_bits_q == 3'd7) begin
                    rx_data_d = {rx_shift_q[6:0], rx_bit};
                    rx_set    = 1'b1;
                end
            end
        end else if (tick && (rx_ival_q != IVAL_MAX)) begin
            rx_ival_d = rx_ival_q + 11'd1;
            if (rx_ival_q == IVAL_MAX - 11'd1) begin
                rx_armed_d = 1'b0;
                rx_bits_d  = 3'd0;
            end
        end
    end

    always_comb begin
        rx_ready_d = rx_ready_q;
        if (data_rd) begin
            rx_ready_d = 1'b0;
        end
        if (rx_set) begin
            rx_ready_d = 1'b1;
        end

        overrun_d = overrun_q;
        if (ctrl_wr && DIN[7]) begin
            overrun_d = 1'b0;
        end
        if (rx_set && rx_ready_q) begin
            overrun_d = 1'b1;
        end

        dout_d = 8'hFF;
        if (rd_en) begin
            unique case (ADDR)
                ADDR_DATA:   dout_d = rx_data_q;
                ADDR_CTRL:   dout_d = status;
                ADDR_PERIOD: dout_d = period_q;
                default:     dout_d = 8'hFF;
            endcase
        end

`ifdef TAPE_CTRL_IRQ_EN
        irq_d = (rxie_q & rx_ready_q) | (txie_q & ~tx_busy);
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q    <= 4'd0;
            period_q   <= PERIOD_RESET;
            rx_en_q    <= 1'b0;
            rxie_q     <= 1'b0;
            txie_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_shift_q <= 8'h00;
            tx_bits_q  <= 3'd0;
            tx_cnt_q   <= 9'd0;
            tape_out_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            rx_prev_q  <= 1'b0;
            rx_armed_q <= 1'b0;
            rx_ival_q  <= 11'd0;
            rx_shift_q <= 8'h00;
            rx_bits_q  <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
            dout_q     <= 8'hFF;
            irq_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples values from before this edge.
            presc_q    <= presc_d;
            period_q   <= period_d;
            rx_en_q    <= rx_en_d;
            rxie_q     <= rxie_d;
            txie_q     <= txie_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bits_q  <= tx_bits_d;
            tx_cnt_q   <= tx_cnt_d;
            tape_out_q <= tape_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            rx_prev_q  <= rx_prev_d;
            rx_armed_q <= rx_armed_d;
            rx_ival_q  <= rx_ival_d;
            rx_shift_q <= rx_shift_d;
            rx_bits_q  <= rx_bits_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            overrun_q  <= overrun_d;
            dout_q     <= dout_d;
            irq_q      <= irq_d;
        end
    end

    assign DOUT     = dout_q;
    assign TAPE_OUT = tape_out_q;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_tape_controller.sv
// Self-checking bench for tape_controller: register vectors, TX waveform scoreboard, RX/overrun,
// reset abort and interrupt behaviour (build with or without TAPE_CTRL_IRQ_EN).

module tb_tape_controller;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CS = 1'b0;
    logic       RD = 1'b0;
    logic       WR = 1'b0;
    logic [1:0] ADDR = 2'd0;
    logic [7:0] DIN = 8'h00;
    logic [7:0] DOUT;
    logic       TAPE_IN = 1'b0;
    logic       TAPE_OUT;
    logic       IRQ;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] tb_presc = 4'd0;

    int         tx_q[$];
    logic [7:0] rd_exp_q[$];

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[15];

    tape_controller dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CS       (CS),
        .RD       (RD),
        .WR       (WR),
        .ADDR     (ADDR),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .TAPE_IN  (TAPE_IN),
        .TAPE_OUT (TAPE_OUT),
        .IRQ      (IRQ)
    );

    always #5 CLK = ~CLK;

    // Reference prescaler phase, used to align TX starts to a tick boundary.
    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        tb_presc <= RESET ? 4'd0 : tb_presc + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                                input logic [7:0] exp);
        vec_t v;
        v.wr   = wr;
        v.addr = addr;
        v.data = data;
        v.exp  = exp;
        return v;
    endfunction

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        @(negedge CLK);
        CS = 1'b1; WR = 1'b1; ADDR = addr; DIN = data;
        @(negedge CLK);
        CS = 1'b0; WR = 1'b0;
    endtask

    // Called at a negedge: read is sampled at the next posedge, result compared one negedge later.
    task automatic do_read(input logic [1:0] addr, input logic [7:0] exp, input string name);
        CS = 1'b1; RD = 1'b1; ADDR = addr;
        rd_exp_q.push_back(exp);
        @(negedge CLK);
        CS = 1'b0; RD = 1'b0;
        check(name, DOUT, rd_exp_q.pop_front());
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [7:0] exp, input string name);
        @(negedge CLK);
        do_read(addr, exp, name);
    endtask

    // Read sampled exactly at posedge number 'edge_n'.
    task automatic read_at(input int edge_n, input logic [1:0] addr, input logic [7:0] exp,
                           input string name);
        @(negedge CLK);
        while (cyc < edge_n - 1) @(negedge CLK);
        do_read(addr, exp, name);
    endtask

    // DATA write sampled on a tick edge; the expected half-bit run lengths go to the scoreboard.
    // The final LOW is covered by the TX_BUSY timing checks instead.
    task automatic tx_start(input logic [7:0] data, input int period, output int e0);
        int len;
        @(negedge CLK);
        while (tb_presc != 4'hF) @(negedge CLK);
        for (int i = 7; i >= 0; i--) begin
            len = 16 * (period + 1) * (data[i] ? 2 : 1);
            tx_q.push_back(len);
            if (i != 0) tx_q.push_back(len);
        end
        CS = 1'b1; WR = 1'b1; ADDR = 2'd0; DIN = data;
        @(posedge CLK);
        #1 e0 = cyc;
        @(negedge CLK);
        CS = 1'b0; WR = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input int period);
        int len;
        for (int i = 7; i >= 0; i--) begin
            len = 16 * (period + 1) * (data[i] ? 2 : 1);
            TAPE_IN = 1'b1;
            repeat (len) @(negedge CLK);
            TAPE_IN = 1'b0;
            repeat (len) @(negedge CLK);
        end
    endtask

    task automatic send_trailer();
        TAPE_IN = 1'b1;
        repeat (16) @(negedge CLK);
        TAPE_IN = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    // TAPE_OUT monitor: HIGH runs close on a fall, LOW runs close on the next rise.
    logic mon_prev = 1'b0;
    int   mon_run = 0;
    bit   mon_in_tx = 1'b0;

    always @(negedge CLK) begin
        if (RESET) begin
            tx_q.delete();
            mon_in_tx = 1'b0;
            mon_run   = 0;
            mon_prev  = TAPE_OUT;
        end else if (TAPE_OUT === mon_prev) begin
            mon_run++;
        end else begin
            if (TAPE_OUT) begin
                if (mon_in_tx) begin
                    check("tx_low_len", mon_run, tx_q.pop_front());
                end else begin
                    check("tx_pulse_expected", tx_q.size() != 0, 1);
                    mon_in_tx = (tx_q.size() != 0);
                end
            end else begin
                check("tx_high_pending", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) check("tx_high_len", mon_run, tx_q.pop_front());
                if (tx_q.size() == 0) mon_in_tx = 1'b0;
            end
            mon_run  = 1;
            mon_prev = TAPE_OUT;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [7:0] ctrl_rb;
        logic       irq_idle_exp;

`ifdef TAPE_CTRL_IRQ_EN
        ctrl_rb      = 8'h70;
        irq_idle_exp = 1'b1;
`else
        ctrl_rb      = 8'h10;
        irq_idle_exp = 1'b0;
`endif

        vecs[0]  = mk(1'b0, 2'd1, 8'h00, 8'h00);
        vecs[1]  = mk(1'b0, 2'd2, 8'h00, 8'h0F);
        vecs[2]  = mk(1'b0, 2'd0, 8'h00, 8'h00);
        vecs[3]  = mk(1'b0, 2'd3, 8'h00, 8'hFF);
        vecs[4]  = mk(1'b1, 2'd2, 8'h33, 8'h00);
        vecs[5]  = mk(1'b0, 2'd2, 8'h00, 8'h33);
        vecs[6]  = mk(1'b1, 2'd3, 8'h55, 8'h00);
        vecs[7]  = mk(1'b0, 2'd3, 8'h00, 8'hFF);
        vecs[8]  = mk(1'b0, 2'd2, 8'h00, 8'h33);
        vecs[9]  = mk(1'b1, 2'd1, 8'h07, 8'h00);
        vecs[10] = mk(1'b0, 2'd1, 8'h00, ctrl_rb);
        vecs[11] = mk(1'b1, 2'd1, 8'h00, 8'h00);
        vecs[12] = mk(1'b0, 2'd1, 8'h00, 8'h00);
        vecs[13] = mk(1'b1, 2'd2, 8'h00, 8'h00);
        vecs[14] = mk(1'b0, 2'd2, 8'h00, 8'h00);

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_dout", DOUT, 8'hFF);
        check("reset_tape_out", TAPE_OUT, 1'b0);
        check("reset_irq", IRQ, 1'b0);
        RESET = 1'b0;

        // Register access vectors
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end
        @(negedge CLK);
        check("dout_idle", DOUT, 8'hFF);

        // TX 0xA5 at PERIOD=0 with an ignored DATA write while busy
        tx_start(8'hA5, 0, e0);
        repeat (3) @(negedge CLK);
        bus_write(2'd0, 8'h00);
        read_at(e0 + 100, 2'd1, 8'h01, "tx_busy_mid");
        read_at(e0 + 384, 2'd1, 8'h01, "tx_busy_last_clk");
        read_at(e0 + 385, 2'd1, 8'h00, "tx_idle_after");
        check("tx_idle_tape_out", TAPE_OUT, 1'b0);
        check("tx_queue_drained", tx_q.size(), 0);

        // RX single byte
        bus_write(2'd1, 8'h01);
        send_byte(8'hA5, 0);
        send_trailer();
        bus_read(2'd1, 8'h12, "rx_ready_status");
        bus_read(2'd0, 8'hA5, "rx_data");
        bus_read(2'd1, 8'h10, "rx_ready_cleared");

        // RX overrun: two back-to-back bytes without a read, then flags survive RX_EN=0
        bus_write(2'd1, 8'h00);
        bus_write(2'd1, 8'h01);
        send_byte(8'h3C, 0);
        send_byte(8'h96, 0);
        send_trailer();
        bus_read(2'd1, 8'h16, "overrun_status");
        bus_write(2'd1, 8'h00);
        bus_read(2'd1, 8'h06, "flags_kept_rx_off");
        bus_read(2'd0, 8'h96, "rx_data_second");
        bus_write(2'd1, 8'h81);
        bus_read(2'd1, 8'h10, "overrun_cleared");
        bus_write(2'd1, 8'h00);

        // Reset in the middle of bit 3 of a transfer
        tx_start(8'hA5, 0, e0);
        @(negedge CLK);
        while (cyc < e0 + 170) @(negedge CLK);
        check("tape_out_before_reset", TAPE_OUT, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        check("tape_out_after_reset", TAPE_OUT, 1'b0);
        check("dout_in_reset", DOUT, 8'hFF);
        @(negedge CLK);
        RESET = 1'b0;
        bus_read(2'd1, 8'h00, "status_after_reset");
        bus_read(2'd2, 8'h0F, "period_after_reset");
        check("irq_after_reset", IRQ, 1'b0);

        // Interrupt on TX idle, plus a PERIOD=1 transfer
        bus_write(2'd2, 8'h01);
        bus_write(2'd1, 8'h04);
        repeat (2) @(negedge CLK);
        check("irq_txie_idle", IRQ, irq_idle_exp);
        tx_start(8'h3C, 1, e0);
        @(negedge CLK);
        check("irq_tx_busy", IRQ, 1'b0);
        repeat (778) @(negedge CLK);
        check("irq_after_tx", IRQ, irq_idle_exp);
        check("tx2_queue_drained", tx_q.size(), 0);
        bus_read(2'd1, {1'b0, irq_idle_exp, 6'b000000}, "status_txie");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
